// File: rtl/scan139_pkg.sv
// scan139_pkg: shared state type, channel width and cyclic next-channel search for the scan sequencer.
package scan139_pkg;
  localparam int CH_W = 2;
  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_e;
  typedef struct packed {
    logic            valid;
    logic            wrapped;
    logic [CH_W-1:0] ch;
  } pick_t;
  function automatic pick_t next_ch(input logic [3:0] mask, input logic [CH_W-1:0] cur);
    pick_t p;
    logic [CH_W-1:0] c;
    p = '0;
    for (int i = 4; i >= 1; i--) begin
      c = cur + CH_W'(i);
      if (mask[c]) begin
        p.valid = 1'b1;
        p.ch    = c;
      end
    end
    p.wrapped = p.valid && (p.ch <= cur);
    return p;
  endfunction
endpackage

// File: rtl/scan139_timer.sv
// scan139_timer: loadable down-counter that parks at zero, shared by the blank and dwell phases.
module scan139_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  always_comb cnt_d = load_i ? val_i : (zero_o ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/scan_sequencer_139.sv
// scan_sequencer_139: drives G/A/B of a 2-to-4 decoder through a masked channel scan with blanking gaps.
module scan_sequencer_139
  import scan139_pkg::*;
#(
  parameter int BLANK_CYC = 1,
  parameter int DWELL_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               oneshot_i,
  input  logic [3:0]         mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               g_o,
  output logic               a_o,
  output logic               b_o,
  output logic [CH_W-1:0]    ch_o,
  output logic               busy_o,
  output logic               done_o
);
  localparam int TW = DWELL_W > 4 ? DWELL_W : 4;
  state_e          state_q, state_d;
  logic            g_q, g_d, busy_q, busy_d, done_q, done_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            load, zero;
  logic [TW-1:0]   val;
  pick_t           pick;
  // From IDLE, searching after channel 3 yields the lowest set mask bit.
  assign pick = next_ch(mask_i, state_q == IDLE ? CH_W'(3) : ch_q);
  scan139_timer #(.W(TW)) u_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load_i(load),
    .val_i (val),
    .zero_o(zero)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      g_q     <= 1'b1;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ch_q    <= ch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    val     = '0;
    if (!en_i) state_d = IDLE;
    else
      case (state_q)
        IDLE:
          if (pick.valid) begin
            state_d = BLANK;
            load    = 1'b1;
            val     = TW'(BLANK_CYC - 1);
          end
        BLANK:
          if (zero) begin
            state_d = ACTIVE;
            load    = 1'b1;
            val     = TW'(dwell_i);
          end
        ACTIVE:
          if (zero) begin
            if (!pick.valid || (oneshot_i && pick.wrapped)) state_d = IDLE;
            else begin
              state_d = BLANK;
              load    = 1'b1;
              val     = TW'(BLANK_CYC - 1);
            end
          end
        default: state_d = IDLE;
      endcase
  end
  // The address moves only on entry to BLANK, the same edge that raises G.
  always_comb begin
    g_d    = state_d != ACTIVE;
    busy_d = state_d != IDLE;
    ch_d   = (state_d == BLANK && state_q != BLANK) ? pick.ch : ch_q;
    done_d = en_i && state_q == ACTIVE && zero && oneshot_i && pick.valid && pick.wrapped;
  end
  assign g_o    = g_q;
  assign a_o    = ch_q[0];
  assign b_o    = ch_q[1];
  assign ch_o   = ch_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_scan_sequencer_139.sv
// tb_scan_sequencer_139: directed and random stimulus checked every cycle against a schedule-queue model.
module tb_scan_sequencer_139;
  localparam int BC = 1;
  localparam int DW = 8;
  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, oneshot = 1'b0;
  logic [3:0]    mask = '0;
  logic [DW-1:0] dwell = '0;
  logic          g, a, b, busy, done;
  logic [1:0]    ch;
  logic [3:0]    y;
  int            checks = 0, errors = 0;
  scan_sequencer_139 #(.BLANK_CYC(BC), .DWELL_W(DW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (en),
    .oneshot_i(oneshot),
    .mask_i   (mask),
    .dwell_i  (dwell),
    .g_o      (g),
    .a_o      (a),
    .b_o      (b),
    .ch_o     (ch),
    .busy_o   (busy),
    .done_o   (done)
  );
  always #5 clk = ~clk;
  // Decoder outputs as the downstream 2-to-4 decoder would drive them.
  assign y = g ? 4'hF : ~(4'b0001 << {b, a});
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Model: a queue holding the G level of every remaining cycle of the current phase.
  bit       seg[$];
  bit       m_run, was_blank;
  logic [1:0] m_ch;
  logic     e_g, e_busy, e_done;
  int       nc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg.delete();
      m_run  = 0;
      m_ch   = 0;
      e_g    = 1;
      e_busy = 0;
      e_done = 0;
    end else begin
      e_done = 0;
      if (!en) begin
        m_run = 0;
        seg.delete();
      end else if (!m_run) begin
        if (mask != 0) begin
          for (int i = 3; i >= 0; i--) if (mask[i]) m_ch = 2'(i);
          m_run = 1;
          repeat (BC) seg.push_back(1);
        end
      end else begin
        was_blank = seg.pop_front();
        if (seg.size() == 0) begin
          if (was_blank) repeat (int'(dwell) + 1) seg.push_back(0);
          else begin
            nc = -1;
            for (int j = 1; j <= 4; j++) if (nc < 0 && mask[(int'(m_ch) + j) % 4]) nc = (int'(m_ch) + j) % 4;
            if (nc < 0) m_run = 0;
            else if (oneshot && nc <= int'(m_ch)) begin
              m_run  = 0;
              e_done = 1;
            end else begin
              m_ch = 2'(nc);
              repeat (BC) seg.push_back(1);
            end
          end
        end
      end
      e_g    = m_run ? seg[0] : 1'b1;
      e_busy = m_run;
    end
  end
  logic [1:0] prev_ch;
  bit         prev_ok = 0;
  always @(negedge rst_n) prev_ok = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ({g, ch, busy, done} !== {e_g, m_ch, e_busy, e_done} || ch !== {b, a}) begin
        errors++;
        $display("FAIL model t=%0t: got g=%b ch=%0d ba=%b%b busy=%b done=%b expected g=%b ch=%0d busy=%b done=%b",
                 $time, g, ch, b, a, busy, done, e_g, m_ch, e_busy, e_done);
      end
      if (prev_ok && !g) begin
        checks++;
        if (ch !== prev_ch) begin
          errors++;
          $display("FAIL glitch t=%0t: ch moved %0d -> %0d while G low", $time, prev_ch, ch);
        end
      end
      prev_ch = ch;
      prev_ok = 1;
    end
  end
  task automatic wait_sig(input bit use_g, input logic val, input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((use_g ? g : busy) === val) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for %b", name, val);
  endtask
  task automatic collect(input int n, output logic [63:0] ay, output logic [15:0] ad, output logic [15:0] ab);
    ay = '0;
    ad = '0;
    ab = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      ay = {ay[59:0], y};
      ad = {ad[14:0], done};
      ab = {ab[14:0], busy};
    end
  endtask
  task automatic restart(input logic os, input logic [3:0] m, input logic [DW-1:0] d);
    en = 0;
    @(posedge clk);
    #1;
    oneshot = os;
    mask    = m;
    dwell   = d;
    en      = 1;
  endtask
  logic [63:0] sy;
  logic [15:0] sd, sb;
  bit          seen;
  initial begin
    #12;
    chk("reset_g", g, 1);
    chk("reset_ch", ch, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1;
    en = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_mask0_busy", busy, 0);
    chk("idle_mask0_g", g, 1);
    restart(0, 4'b1111, 3);
    wait_sig(0, 1, "cont_start");
    collect(15, sy, sd, sb);
    chk("cont_scan_y", sy, 64'hFEEEEFDDDDFBBBB);
    restart(0, 4'b1010, 0);
    wait_sig(0, 1, "skip_start");
    collect(8, sy, sd, sb);
    chk("masked_skip_y", sy, 64'hFDF7FDF7);
    restart(1, 4'b0110, 2);
    wait_sig(0, 1, "oneshot_start");
    collect(9, sy, sd, sb);
    en = 0;
    chk("oneshot_y", sy, 64'hFDDDFBBBF);
    chk("oneshot_done", sd, 16'b000000001);
    chk("oneshot_busy", sb, 16'b111111110);
    restart(0, 4'b1100, 3);
    wait_sig(1, 0, "abort_ch2");
    wait_sig(1, 1, "abort_blank");
    wait_sig(1, 0, "abort_ch3");
    @(negedge clk);
    en = 0;
    @(negedge clk);
    chk("abort_g", g, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hold_ch", ch, 3);
    en = 1;
    wait_sig(0, 1, "abort_restart");
    chk("restart_ch", ch, 2);
    restart(1, 4'b1111, 4);
    wait_sig(1, 0, "mask0_active");
    @(negedge clk);
    mask = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= done;
    end
    chk("mask0_no_done", seen, 0);
    chk("mask0_idle", busy, 0);
    restart(0, 4'b1000, 5);
    wait_sig(1, 0, "rst_active");
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_g", g, 1);
    chk("async_rst_ch", ch, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      en = $urandom_range(0, 39) != 0;
      if ($urandom_range(0, 19) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 49) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 19) == 0) dwell = DW'($urandom_range(0, 5));
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 0;
        #1 rst_n = 1;
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
